// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: load-use stall in ID, full freeze during dcache miss, wrong-path squash on EX redirect.
// Outputs are combinational from state and inputs; stall counter and sticky timeout error are registered.
module hazard_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Opcode_IFID,
  input  logic [2:0]       RegisterRs_IFID,
  input  logic [2:0]       RegisterRt_IFID,
  input  logic             MemRead_IDEX,
  input  logic [2:0]       RegisterRd_IDEX,
  input  logic             RegWrite_IDEX,
  input  logic             branch_taken_EX,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  typedef enum logic {S_RUN, S_MEM_WAIT} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               r_err;

  logic w_rs_used;
  logic w_rt_used;
  logic w_lu;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_bubble;
  logic w_ifid_flush;
  logic w_pipe_freeze;

  always_comb begin
    w_rs_used = 1'b0;
    w_rt_used = 1'b0;
    casez (Opcode_IFID)
      5'b11010, 5'b11011, 5'b111??, 5'b10000, 5'b10011: begin
        w_rs_used = 1'b1;
        w_rt_used = 1'b1;
      end
      5'b01???, 5'b10001, 5'b10010, 5'b101??, 5'b11001, 5'b00101, 5'b00111: begin
        w_rs_used = 1'b1;
      end
      default: begin
        w_rs_used = 1'b0;
        w_rt_used = 1'b0;
      end
    endcase
  end

  // Register 0 is a real architectural register, so no zero-index exclusion.
  assign w_lu = MemRead_IDEX & RegWrite_IDEX &
                ((w_rs_used & (RegisterRs_IFID == RegisterRd_IDEX)) |
                 (w_rt_used & (RegisterRt_IFID == RegisterRd_IDEX)));

  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_bubble = 1'b0;
    w_ifid_flush  = 1'b0;
    w_pipe_freeze = 1'b0;
    w_next_state  = r_state;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          if (dmem_stall && !dmem_done) begin
            w_pipe_freeze = 1'b1;
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_next_state  = S_MEM_WAIT;
          end else if (branch_taken_EX) begin
            // ID holds a wrong-path instruction, so its load-use hazard is moot.
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          w_pipe_freeze = 1'b1;
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          if (dmem_done) begin
            w_next_state = S_RUN;
          end
        end
        default: begin
          w_next_state = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_MEM_WAIT && !dmem_done) begin
        if (r_wait_cnt == WAIT_MAX) begin
          r_err <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
      if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign PCWrite     = w_pc_write;
  assign IFID_Write  = w_ifid_write;
  assign IDEX_bubble = w_idex_bubble;
  assign IFID_flush  = w_ifid_flush;
  assign pipe_freeze = w_pipe_freeze;
  assign stall_cnt   = r_stall_cnt;
  assign err         = r_err;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios then random traffic, all checked against a cycle model.
module tb_hazard_stall_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       Opcode_IFID = '0;
  logic [2:0]       RegisterRs_IFID = '0;
  logic [2:0]       RegisterRt_IFID = '0;
  logic             MemRead_IDEX = 1'b0;
  logic [2:0]       RegisterRd_IDEX = '0;
  logic             RegWrite_IDEX = 1'b0;
  logic             branch_taken_EX = 1'b0;
  logic             dmem_stall = 1'b0;
  logic             dmem_done = 1'b0;
  logic             PCWrite, IFID_Write, IDEX_bubble, IFID_flush, pipe_freeze, err;
  logic [CNT_W-1:0] stall_cnt;

  hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Opcode_IFID(Opcode_IFID), .RegisterRs_IFID(RegisterRs_IFID), .RegisterRt_IFID(RegisterRt_IFID),
    .MemRead_IDEX(MemRead_IDEX), .RegisterRd_IDEX(RegisterRd_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
    .branch_taken_EX(branch_taken_EX), .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush),
    .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: frozen flag, count of MEM_WAIT cycles, sticky error, stall count.
  bit m_frozen, m_err;
  int m_wait, m_stall;
  bit e_pc, e_ifw, e_bub, e_fl, e_frz;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rs_use(input logic [4:0] op);
    int v;
    v = int'(op);
    return v inside {5, 7, [8:23], [25:31]};
  endfunction

  function automatic bit rt_use(input logic [4:0] op);
    int v;
    v = int'(op);
    return v inside {16, 19, [26:31]};
  endfunction

  function automatic bit load_use();
    return MemRead_IDEX && RegWrite_IDEX &&
           ((rs_use(Opcode_IFID) && RegisterRs_IFID == RegisterRd_IDEX) ||
            (rt_use(Opcode_IFID) && RegisterRt_IFID == RegisterRd_IDEX));
  endfunction

  task automatic model_reset();
    m_frozen = 0; m_err = 0; m_wait = 0; m_stall = 0;
  endtask

  task automatic predict();
    e_pc = 1; e_ifw = 1; e_bub = 0; e_fl = 0; e_frz = 0;
    if (rst) begin
      // reset values already set
    end else if (m_frozen || (dmem_stall && !dmem_done)) begin
      e_frz = 1; e_pc = 0; e_ifw = 0;
    end else if (branch_taken_EX) begin
      e_fl = 1; e_bub = 1;
    end else if (load_use()) begin
      e_pc = 0; e_ifw = 0; e_bub = 1;
    end
  endtask

  task automatic advance();
    if (!e_pc && m_stall < SAT) m_stall++;
    if (!m_frozen) begin
      if (dmem_stall && !dmem_done) begin
        m_frozen = 1;
        m_wait = 0;
      end
    end else if (dmem_done) begin
      m_frozen = 0;
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait >= TIMEOUT) m_err = 1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    if (rst) model_reset();
    predict();
    chk("PCWrite", PCWrite, e_pc);
    chk("IFID_Write", IFID_Write, e_ifw);
    chk("IDEX_bubble", IDEX_bubble, e_bub);
    chk("IFID_flush", IFID_flush, e_fl);
    chk("pipe_freeze", pipe_freeze, e_frz);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("err", err, m_err);
    @(posedge clk);
    if (rst) model_reset(); else advance();
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic mr, input logic [2:0] rd, input logic rw,
                       input logic br, input logic ds, input logic dd);
    Opcode_IFID = op; RegisterRs_IFID = rs; RegisterRt_IFID = rt;
    MemRead_IDEX = mr; RegisterRd_IDEX = rd; RegWrite_IDEX = rw;
    branch_taken_EX = br; dmem_stall = ds; dmem_done = dd;
  endtask

  task automatic idle();
    drive(5'b00000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    idle();
    step();
    step();
    rst = 1'b0;
    step();

    // Load-use on Rs: LD Rd=3 in EX, ADD Rs=3 Rt=5 in ID.
    drive(5'b11011, 3'd3, 3'd5, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'b11011, 3'd3, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("lu_stall_cnt", stall_cnt, 1);

    // ADDI only reads Rs, so a matching Rt field must not stall.
    drive(5'b01000, 3'd1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'b10000, 3'd1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'b11011, 3'd0, 3'd4, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("r0_stall_cnt", stall_cnt, 3);

    // Branch beats load-use.
    drive(5'b11011, 3'd3, 3'd5, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("br_stall_cnt", stall_cnt, 3);

    // Cache miss: five stall cycles then done -> six frozen cycles.
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(5'b11011, 3'd3, 3'd5, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    drive(5'b00000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    idle();
    step();
    chk("miss_stall_cnt", stall_cnt, 6);
    chk("miss_err", err, 0);

    // Stall and done together in RUN: no freeze.
    drive(5'b00000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();

    // Timeout: err after the 8th MEM_WAIT cycle, sticky, then async reset mid-wait.
    pulse_reset();
    drive(5'b00000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("err_before_timeout", err, 0);
    step();
    chk("err_at_timeout", err, 1);
    dmem_stall = 1'b0;
    step();
    step();
    chk("err_sticky", err, 1);
    drive(5'b11011, 3'd3, 3'd5, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_err", err, 0);
    rst = 1'b0;
    idle();
    step();
    chk("post_rst_freeze", pipe_freeze, 0);

    // Saturation of the narrow stall counter.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive(5'b10011, 3'd6, 3'd1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("sat_stall_cnt", stall_cnt, SAT);

    // Random traffic; narrow register range makes hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      Opcode_IFID     = 5'($urandom_range(0, 31));
      RegisterRs_IFID = 3'($urandom_range(0, 3));
      RegisterRt_IFID = 3'($urandom_range(0, 3));
      RegisterRd_IDEX = 3'($urandom_range(0, 3));
      MemRead_IDEX    = ($urandom_range(0, 1) == 1);
      RegWrite_IDEX   = ($urandom_range(0, 9) < 7);
      branch_taken_EX = ($urandom_range(0, 6) == 0);
      if (m_frozen) begin
        dmem_stall = ($urandom_range(0, 3) != 0);
        dmem_done  = ($urandom_range(0, 9) < 2);
      end else begin
        dmem_stall = ($urandom_range(0, 9) == 0);
        dmem_done  = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline interlock and stall controller, the counterpart of the EX-stage forwarding logic. It detects in ID the hazards that forwarding cannot resolve (load-use) and freezes the whole pipeline while the data cache services a miss. It squashes wrong-path instructions on a taken branch or jump resolved in EX, and counts stall cycles for performance reporting. It sits beside the IF/ID and ID/EX pipeline registers and drives their write enables, bubble inputs and flush inputs, plus the PC write enable.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter
TIMEOUT, 64, dmem wait cycles before err asserts (minimum 2)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-high reset
Opcode_IFID  input  5  opcode of the instruction in ID
RegisterRs_IFID  input  3  Rs field of the instruction in ID
RegisterRt_IFID  input  3  Rt field of the instruction in ID
MemRead_IDEX  input  1  instruction in EX is a load (LD)
RegisterRd_IDEX  input  3  destination register of the instruction in EX
RegWrite_IDEX  input  1  instruction in EX writes a register
branch_taken_EX  input  1  taken branch or jump resolved in EX this cycle
dmem_stall  input  1  data cache is busy (miss in progress)
dmem_done  input  1  data cache has completed the access this cycle
PCWrite  output  1  PC update enable
IFID_Write  output  1  IF/ID register write enable
IDEX_bubble  output  1  insert a NOP into ID/EX
IFID_flush  output  1  clear IF/ID to a NOP
pipe_freeze  output  1  hold all pipeline registers (EX/MEM, MEM/WB included)
stall_cnt  output  CNT_W  saturating count of cycles in which PCWrite=0
err  output  1  sticky: dmem wait exceeded TIMEOUT

Behaviour:
- Source-use decode in ID:
  - rs_used = 1 for opcodes 11010, 11011, 11100–11111, 01000–01111, 10000, 10001, 10010, 10011, 10100–10111, 11001, 00101, 00111.
  - rt_used = 1 for 11010, 11011, 11100–11111, 10000 (ST) and 10011 (STU).
  - All other opcodes use neither source.
- Load-use hazard: lu = MemRead_IDEX & RegWrite_IDEX & ((rs_used & Rs==Rd_IDEX) | (rt_used & Rt==Rd_IDEX)). Register 0 is a real register; it is not excluded.
- FSM states: RUN, MEM_WAIT. The state and counters are registered. Outputs are combinational from state and inputs.
- RUN, in priority order:
  - dmem_stall=1 & dmem_done=0: pipe_freeze=1, PCWrite=0, IFID_Write=0, bubble=0, flush=0; next state MEM_WAIT.
  - Else branch_taken_EX=1: IFID_flush=1, IDEX_bubble=1, PCWrite=1, IFID_Write=1. The flush overrides lu because the instruction in ID is wrong-path.
  - Else lu=1: PCWrite=0, IFID_Write=0, IDEX_bubble=1 for exactly one cycle. The next cycle has MemRead_IDEX=0, so lu clears and the consumer proceeds; MEM->EX forwarding supplies the data.
  - Else: PCWrite=1, IFID_Write=1, all other outputs 0.
- MEM_WAIT:
  - pipe_freeze=1, PCWrite=0, IFID_Write=0, bubble=0, flush=0.
  - wait_cnt increments each cycle.
  - dmem_done=1: next state RUN and wait_cnt cleared. That cycle is still frozen; the pipeline advances on the following edge.
  - wait_cnt reaching TIMEOUT-1 without done: err sets (sticky until rst) and the FSM stays in MEM_WAIT.
  - branch_taken_EX and lu are ignored while frozen; they are re-evaluated in RUN.
- dmem_stall and dmem_done both 1 in RUN: the access completed with no wait; no freeze.
- stall_cnt increments on every cycle with PCWrite=0 (load-use and freeze) and saturates at all-ones.
- Reset (async, any state, including mid-MEM_WAIT):
  - state=RUN, wait_cnt=0, stall_cnt=0, err=0.
  - While rst=1 the outputs are forced to PCWrite=1, IFID_Write=1, IDEX_bubble=0, IFID_flush=0, pipe_freeze=0.

Test Plan:
- Load-use on Rs: EX has LD with Rd=3; ID has ADD (11011) with Rs=3, Rt=5 -> one cycle of PCWrite=0, IFID_Write=0, IDEX_bubble=1; next cycle normal; stall_cnt=1.
- No false stall: EX has LD Rd=2; ID has ADDI (01000) whose Rt field=2 -> no stall. Same LD with ST (10000) Rt=2 -> stall. LD with Rd=0 and ADD Rs=0 -> stall.
- Branch versus load-use: branch_taken_EX=1 with lu=1 in the same cycle -> IFID_flush=1, IDEX_bubble=1, PCWrite=1, and no load-use stall.
- Cache miss: dmem_stall high for 5 cycles, then dmem_done -> pipe_freeze=1 for 6 cycles total, return to RUN, stall_cnt += 6, err=0.
- Timeout and reset: TIMEOUT=8, dmem_stall held with no done -> err=1 after the 8th wait cycle and stays 1. Assert rst mid-wait -> all outputs return to reset values immediately, FSM in RUN.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt holds at 15.
